// File: rtl/scsi_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scsi_arb_pkg
//  Description : Shared definitions for the SCSI / Zorro III bus arbiter:
//                state encodings, default timing constants and the
//                state-to-output decode used by the arbiter.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package scsi_arb_pkg;

    localparam int C_HOLDOFF_DEFAULT = 4;
    localparam int C_TIMEOUT_DEFAULT = 255;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t C_ST_IDLE    = 3'd0;
    localparam arb_state_t C_ST_REQ     = 3'd1;
    localparam arb_state_t C_ST_GRANT   = 3'd2;
    localparam arb_state_t C_ST_OWN     = 3'd3;
    localparam arb_state_t C_ST_RELEASE = 3'd4;

    typedef struct packed {
        logic breq_n;
        logic bg_n;
        logic mybus;
    } arb_out_t;

    localparam arb_out_t C_OUT_IDLE = '{breq_n: 1'b1, bg_n: 1'b1, mybus: 1'b0};

    // Unknown encodings decode to the idle (all-released) output set.
    function automatic arb_out_t f_decode(input arb_state_t st);
        arb_out_t o;
        o = C_OUT_IDLE;
        case (st)
            C_ST_REQ: begin
                o.breq_n = 1'b0;
            end
            C_ST_GRANT: begin
                o.breq_n = 1'b0;
                o.bg_n   = 1'b0;
            end
            C_ST_OWN: begin
                o.breq_n = 1'b0;
                o.mybus  = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scsi_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : scsi_bus_arbiter_if
//  Description : Bus-side handshake bundle of the arbiter.
//  Signals     : BR_n/BGACK_n (NCR request/acknowledge), BGRANT_n (Zorro
//                grant), scsi_cycle (host register access), BG_n (grant to
//                NCR), BREQ_n (Zorro request), mybus (NCR owns bus),
//                bus_timeout (grant timeout pulse)
//  Modports    : master - environment side, drives the requests
//                slave  - arbiter side, drives the grants
//  Revision    : 1.0 - initial release
// ============================================================================
interface scsi_bus_arbiter_if;
    logic BR_n;
    logic BGACK_n;
    logic BGRANT_n;
    logic scsi_cycle;
    logic BG_n;
    logic BREQ_n;
    logic mybus;
    logic bus_timeout;

    modport master (
        output BR_n, BGACK_n, BGRANT_n, scsi_cycle,
        input  BG_n, BREQ_n, mybus, bus_timeout
    );

    modport slave (
        input  BR_n, BGACK_n, BGRANT_n, scsi_cycle,
        output BG_n, BREQ_n, mybus, bus_timeout
    );
endinterface
`default_nettype wire

// File: rtl/scsi_bus_arbiter_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchronizer on the falling edge of bclk; resets
//                to the inactive (high) level of an active-low input.
//  Ports       : bclk, RESET_n (async active-low), i_d (async in),
//                o_q (synchronized out)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync2 (
    input  wire logic bclk,
    input  wire logic RESET_n,
    input  wire logic i_d,
    output logic      o_q
);
    logic [1:0] r_sync_q;
    logic [1:0] w_sync_d;

    always_comb begin
        w_sync_d = {r_sync_q[0], i_d};
    end

    always_ff @(negedge bclk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_sync_q <= 2'b11;
        end else begin
            r_sync_q <= w_sync_d;
        end
    end

    assign o_q = r_sync_q[1];
endmodule
`default_nettype wire

// File: rtl/scsi_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : scsi_bus_arbiter
//  Description : Arbitrates the Zorro III bus for the NCR SCSI controller.
//                The NCR request is forwarded to Zorro only when no host
//                register access is active and the post-release holdoff has
//                expired. State updates on the falling edge of bclk; all
//                outputs are registered, decoded from the next state.
//  Ports       : bclk      - clock (falling edge active)
//                RESET_n   - asynchronous active-low reset
//                bus       - scsi_bus_arbiter_if.slave handshake bundle
//  Options     : SCSI_ARB_TIMEOUT_EN - abort REQ/GRANT after TIMEOUT_CYCLES
//                and pulse bus_timeout; otherwise bus_timeout is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module scsi_bus_arbiter
    import scsi_arb_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = C_HOLDOFF_DEFAULT,
    parameter int TIMEOUT_CYCLES = C_TIMEOUT_DEFAULT
) (
    input  wire logic         bclk,
    input  wire logic         RESET_n,
    scsi_bus_arbiter_if.slave bus
);
    localparam int C_HOLD_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [C_HOLD_W-1:0] C_HOLD_LOAD = C_HOLD_W'(HOLDOFF_CYCLES);

    logic                w_br_s;
    logic                w_bgack_s;
    logic                w_bgrant_s;
    arb_state_t          r_state_q;
    arb_state_t          w_state_d;
    logic [C_HOLD_W-1:0] r_hold_q;
    logic [C_HOLD_W-1:0] w_hold_d;
    arb_out_t            r_out_q;
    arb_out_t            w_out_d;
    logic                w_waiting;
    logic                w_tmo_hit;

    sync2 u_sync_br     (.bclk(bclk), .RESET_n(RESET_n), .i_d(bus.BR_n),     .o_q(w_br_s));
    sync2 u_sync_bgack  (.bclk(bclk), .RESET_n(RESET_n), .i_d(bus.BGACK_n),  .o_q(w_bgack_s));
    sync2 u_sync_bgrant (.bclk(bclk), .RESET_n(RESET_n), .i_d(bus.BGRANT_n), .o_q(w_bgrant_s));

    assign w_waiting = (r_state_q == C_ST_REQ) || (r_state_q == C_ST_GRANT);

`ifdef SCSI_ARB_TIMEOUT_EN
    localparam int C_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(TIMEOUT_CYCLES - 1);

    logic [C_TMO_W-1:0] r_tcnt_q;
    logic [C_TMO_W-1:0] w_tcnt_d;
    logic               r_tmo_q;

    // The count spans REQ and GRANT together: it clears only on entry to REQ.
    assign w_tmo_hit = w_waiting && (r_tcnt_q == C_TMO_LAST);

    always_comb begin
        w_tcnt_d = r_tcnt_q;
        if ((w_state_d == C_ST_REQ) && (r_state_q != C_ST_REQ)) begin
            w_tcnt_d = '0;
        end else if (w_waiting) begin
            w_tcnt_d = r_tcnt_q + 1'b1;
        end
    end

    always_ff @(negedge bclk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_tcnt_q <= '0;
            r_tmo_q  <= 1'b0;
        end else begin
            r_tcnt_q <= w_tcnt_d;
            r_tmo_q  <= w_tmo_hit;
        end
    end

    assign bus.bus_timeout = r_tmo_q;
`else
    assign w_tmo_hit       = 1'b0;
    assign bus.bus_timeout = 1'b0;
`endif

    // State register (with the holdoff counter that travels with it)
    always_ff @(negedge bclk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state_q <= C_ST_IDLE;
            r_hold_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_hold_q  <= w_hold_d;
        end
    end

    // Next-state logic. scsi_cycle is only consulted in IDLE, so a granted
    // NCR transfer is never pre-empted by a host access. A withdrawn request
    // takes priority over a grant arriving on the same edge.
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            C_ST_IDLE: begin
                if (!w_br_s && !bus.scsi_cycle && (r_hold_q == '0)) begin
                    w_state_d = C_ST_REQ;
                end
            end
            C_ST_REQ: begin
                if (w_tmo_hit || w_br_s) begin
                    w_state_d = C_ST_IDLE;
                end else if (!w_bgrant_s) begin
                    w_state_d = C_ST_GRANT;
                end
            end
            C_ST_GRANT: begin
                if (w_tmo_hit) begin
                    w_state_d = C_ST_IDLE;
                end else if (!w_bgack_s) begin
                    w_state_d = C_ST_OWN;
                end else if (w_br_s) begin
                    w_state_d = C_ST_IDLE;
                end
            end
            C_ST_OWN: begin
                if (w_bgack_s) begin
                    w_state_d = C_ST_RELEASE;
                end
            end
            C_ST_RELEASE: begin
                w_state_d = C_ST_IDLE;
            end
            default: begin
                w_state_d = C_ST_IDLE;
            end
        endcase
    end

    // Holdoff: loaded on entering RELEASE or on a timeout abort, then counted
    // down in IDLE; a new request is blocked until it reaches zero.
    always_comb begin
        w_hold_d = r_hold_q;
        if ((w_state_d == C_ST_RELEASE) || w_tmo_hit) begin
            w_hold_d = C_HOLD_LOAD;
        end else if ((r_state_q == C_ST_IDLE) && (r_hold_q != '0)) begin
            w_hold_d = r_hold_q - 1'b1;
        end
    end

    // Output logic: decoded from the next state so the registered outputs
    // change on the same edge as the state.
    always_comb begin
        w_out_d = f_decode(w_state_d);
    end

    always_ff @(negedge bclk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_out_q <= C_OUT_IDLE;
        end else begin
            r_out_q <= w_out_d;
        end
    end

    assign bus.BREQ_n = r_out_q.breq_n;
    assign bus.BG_n   = r_out_q.bg_n;
    assign bus.mybus  = r_out_q.mybus;
endmodule
`default_nettype wire
